// File: rtl/ysyx_lsu_if.sv
// Request/response data bus between the LSU (master) and the data memory (slave).
interface ysyx_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wstrb,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wstrb,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/ysyx_lsu.sv
// Memory-access stage: one instruction in flight, performs its load/store over
// the data bus, formats load data and hands the result to writeback.
module ysyx_lsu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            prev_valid,
  output logic            ready_o,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] inst_i,
  input  logic            ebreak_i,
  input  logic [4:0]      rd_i,
  input  logic [XLEN-1:0] result_i,
  input  logic [XLEN-1:0] sdata_i,
  input  logic            mem_ren_i,
  input  logic            mem_wen_i,
  input  logic [2:0]      funct3_i,
  ysyx_lsu_if.master      bus,
  input  logic            next_ready,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] inst_o,
  output logic            ebreak_o,
  output logic [4:0]      rd_o,
  output logic [XLEN-1:0] wdata_o,
  output logic            err_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] bwdata_q;
  logic [3:0]  wstrb_q;
  logic        wen_q;
  logic [2:0]  f3_q;

  logic        bad;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;
  logic [31:0] ld_shift;
  logic [31:0] ld_data;

  always_comb begin
    bad = 1'b0;
    case (funct3_i)
      3'b000:  bad = 1'b0;
      3'b001:  bad = result_i[0];
      3'b010:  bad = |result_i[1:0];
      3'b100:  bad = mem_wen_i;
      3'b101:  bad = mem_wen_i | result_i[0];
      default: bad = 1'b1;
    endcase
    if (mem_ren_i && mem_wen_i) bad = 1'b1;

    st_wstrb = '0;
    st_wdata = '0;
    case (funct3_i[1:0])
      2'b00: begin
        st_wstrb = 4'b0001 << result_i[1:0];
        st_wdata = {4{sdata_i[7:0]}};
      end
      2'b01: begin
        st_wstrb = 4'b0011 << result_i[1:0];
        st_wdata = {2{sdata_i[15:0]}};
      end
      default: begin
        st_wstrb = 4'hF;
        st_wdata = sdata_i;
      end
    endcase

    // Addressed byte/halfword is moved down to lane 0 before sizing.
    ld_shift = bus.rsp_rdata >> {addr_q[1:0], 3'b000};
    case (f3_q)
      3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_data = {24'h0, ld_shift[7:0]};
      3'b101:  ld_data = {16'h0, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

  assign ready_o       = (state == S_IDLE);
  assign valid_o       = (state == S_DONE);
  assign bus.req_valid = (state == S_REQ);
  assign bus.req_addr  = {addr_q[31:2], 2'b00};
  assign bus.req_wen   = wen_q;
  assign bus.req_wdata = bwdata_q;
  assign bus.req_wstrb = wstrb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      pc_o     <= '0;
      inst_o   <= '0;
      ebreak_o <= 1'b0;
      rd_o     <= '0;
      wdata_o  <= '0;
      err_o    <= 1'b0;
      addr_q   <= '0;
      bwdata_q <= '0;
      wstrb_q  <= '0;
      wen_q    <= 1'b0;
      f3_q     <= '0;
    end else begin
      case (state)
        S_IDLE: if (prev_valid) begin
          pc_o     <= pc_i;
          inst_o   <= inst_i;
          ebreak_o <= ebreak_i;
          rd_o     <= rd_i;
          wdata_o  <= result_i;
          err_o    <= 1'b0;
          addr_q   <= result_i;
          f3_q     <= funct3_i;
          wen_q    <= mem_wen_i;
          wstrb_q  <= mem_wen_i ? st_wstrb : '0;
          bwdata_q <= mem_wen_i ? st_wdata : '0;
          if (!(mem_ren_i || mem_wen_i)) begin
            state <= S_DONE;
          end else if (bad) begin
            err_o   <= 1'b1;
            wdata_o <= '0;
            state   <= S_DONE;
          end else begin
            state <= S_REQ;
          end
        end
        S_REQ: if (bus.req_ready) state <= S_WAIT;
        S_WAIT: if (bus.rsp_valid) begin
          state <= S_DONE;
          if (bus.rsp_err) begin
            err_o   <= 1'b1;
            wdata_o <= '0;
          end else if (!wen_q) begin
            wdata_o <= ld_data;
          end
        end
        S_DONE: if (next_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_lsu.sv
// Bench for ysyx_lsu: vector table driven through a scoreboard, plus
// hand-written sequences for bus stalls, writeback back-pressure and reset in WAIT.
module tb_ysyx_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        prev_valid;
  logic        ready_o;
  logic [31:0] pc_i, inst_i, result_i, sdata_i;
  logic        ebreak_i, mem_ren_i, mem_wen_i;
  logic [4:0]  rd_i;
  logic [2:0]  funct3_i;
  logic        next_ready;
  logic        valid_o;
  logic [31:0] pc_o, inst_o, wdata_o;
  logic        ebreak_o, err_o;
  logic [4:0]  rd_o;

  ysyx_lsu_if bus ();

  ysyx_lsu #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .prev_valid (prev_valid),
    .ready_o    (ready_o),
    .pc_i       (pc_i),
    .inst_i     (inst_i),
    .ebreak_i   (ebreak_i),
    .rd_i       (rd_i),
    .result_i   (result_i),
    .sdata_i    (sdata_i),
    .mem_ren_i  (mem_ren_i),
    .mem_wen_i  (mem_wen_i),
    .funct3_i   (funct3_i),
    .bus        (bus),
    .next_ready (next_ready),
    .valid_o    (valid_o),
    .pc_o       (pc_o),
    .inst_o     (inst_o),
    .ebreak_o   (ebreak_o),
    .rd_o       (rd_o),
    .wdata_o    (wdata_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] result;
    logic [31:0] sdata;
    logic        ren;
    logic        wen;
    logic [2:0]  f3;
    logic        ebreak;
    logic        has_req;
    logic [31:0] rdata;
    logic        rerr;
    logic [31:0] e_addr;
    logic        e_wen;
    logic [3:0]  e_wstrb;
    logic [31:0] e_bwdata;
    logic [31:0] e_wdata;
    logic        e_err;
    int unsigned e_lat;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ebreak;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        err;
  } exp_t;

  localparam int unsigned NVEC = 17;
  vec_t vecs [NVEC];
  exp_t sb [$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("valid_o", {31'd0, valid_o}, 32'd1);
      check("pc_o", pc_o, e.pc);
      check("inst_o", inst_o, e.inst);
      check("ebreak_o", {31'd0, ebreak_o}, {31'd0, e.ebreak});
      check("rd_o", {27'd0, rd_o}, {27'd0, e.rd});
      check("wdata_o", wdata_o, e.wdata);
      check("err_o", {31'd0, err_o}, {31'd0, e.err});
    end
  endtask

  task automatic drive_op(input logic [31:0] pc, input logic [31:0] inst, input logic [4:0] rd,
                          input vec_t v);
    pc_i       = pc;
    inst_i     = inst;
    rd_i       = rd;
    ebreak_i   = v.ebreak;
    result_i   = v.result;
    sdata_i    = v.sdata;
    mem_ren_i  = v.ren;
    mem_wen_i  = v.wen;
    funct3_i   = v.f3;
    prev_valid = 1'b1;
  endtask

  task automatic do_vec(input int unsigned i);
    vec_t        v;
    exp_t        e;
    int unsigned cyc;
    logic [31:0] pc, inst;
    logic [4:0]  rd;
    v    = vecs[i];
    pc   = 32'h8000_0000 + (i << 2);
    inst = 32'h1000_0000 + i;
    rd   = 5'(i + 1);
    @(negedge clk);
    check("idle_ready", {31'd0, ready_o}, 32'd1);
    check("idle_valid", {31'd0, valid_o}, 32'd0);
    drive_op(pc, inst, rd, v);
    next_ready = 1'b1;
    e = '{pc: pc, inst: inst, ebreak: v.ebreak, rd: rd, wdata: v.e_wdata, err: v.e_err};
    sb.push_back(e);
    @(negedge clk);
    prev_valid = 1'b0;
    cyc = 1;
    if (v.has_req) begin
      check("req_valid", {31'd0, bus.req_valid}, 32'd1);
      check("req_addr", bus.req_addr, v.e_addr);
      check("req_wen", {31'd0, bus.req_wen}, {31'd0, v.e_wen});
      check("req_wstrb", {28'd0, bus.req_wstrb}, {28'd0, v.e_wstrb});
      check("req_wdata", bus.req_wdata, v.e_bwdata);
      check("busy_ready", {31'd0, ready_o}, 32'd0);
      bus.req_ready = 1'b1;
      @(negedge clk);
      bus.req_ready = 1'b0;
      cyc++;
      check("req_drop", {31'd0, bus.req_valid}, 32'd0);
      bus.rsp_valid = 1'b1;
      bus.rsp_rdata = v.rdata;
      bus.rsp_err   = v.rerr;
      @(negedge clk);
      bus.rsp_valid = 1'b0;
      bus.rsp_err   = 1'b0;
      cyc++;
    end else begin
      check("no_req", {31'd0, bus.req_valid}, 32'd0);
    end
    while (!valid_o && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, v.e_lat);
    compare_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    exp_t e;
    //          result        sdata         ren wen f3     eb req rdata         rerr e_addr        ewen wstrb  bwdata        wdata         err lat
    vecs[0]  = '{32'h0000_1234, 32'h0,        0, 0, 3'b000, 0, 0, 32'h0,        0, 32'h0,        0, 4'h0, 32'h0,        32'h0000_1234, 0, 1};
    vecs[1]  = '{32'h8000_0003, 32'h0,        1, 0, 3'b000, 0, 1, 32'h80FF_0000, 0, 32'h8000_0000, 0, 4'h0, 32'h0,        32'hFFFF_FF80, 0, 3};
    vecs[2]  = '{32'h8000_0003, 32'h0,        1, 0, 3'b100, 0, 1, 32'h80FF_0000, 0, 32'h8000_0000, 0, 4'h0, 32'h0,        32'h0000_0080, 0, 3};
    vecs[3]  = '{32'h8000_0002, 32'h0,        1, 0, 3'b101, 0, 1, 32'h80FF_0000, 0, 32'h8000_0000, 0, 4'h0, 32'h0,        32'h0000_80FF, 0, 3};
    vecs[4]  = '{32'h8000_0000, 32'h0,        1, 0, 3'b001, 0, 1, 32'h1234_8001, 0, 32'h8000_0000, 0, 4'h0, 32'h0,        32'hFFFF_8001, 0, 3};
    vecs[5]  = '{32'h8000_0001, 32'h0,        1, 0, 3'b000, 0, 1, 32'h0000_7F00, 0, 32'h8000_0000, 0, 4'h0, 32'h0,        32'h0000_007F, 0, 3};
    vecs[6]  = '{32'h8000_0004, 32'h0,        1, 0, 3'b010, 0, 1, 32'hDEAD_BEEF, 0, 32'h8000_0004, 0, 4'h0, 32'h0,        32'hDEAD_BEEF, 0, 3};
    vecs[7]  = '{32'h8000_0001, 32'h1234_56AB, 0, 1, 3'b000, 0, 1, 32'h0,       0, 32'h8000_0000, 1, 4'h2, 32'hABAB_ABAB, 32'h8000_0001, 0, 3};
    vecs[8]  = '{32'h8000_0002, 32'h0000_BEEF, 0, 1, 3'b001, 0, 1, 32'h0,       0, 32'h8000_0000, 1, 4'hC, 32'hBEEF_BEEF, 32'h8000_0002, 0, 3};
    vecs[9]  = '{32'h8000_0008, 32'hCAFE_F00D, 0, 1, 3'b010, 0, 1, 32'h0,       0, 32'h8000_0008, 1, 4'hF, 32'hCAFE_F00D, 32'h8000_0008, 0, 3};
    vecs[10] = '{32'h8000_0002, 32'h0,        1, 0, 3'b010, 0, 0, 32'h0,        0, 32'h0,        0, 4'h0, 32'h0,        32'h0,        1, 1};
    vecs[11] = '{32'h8000_0000, 32'h5555_5555, 1, 1, 3'b010, 0, 0, 32'h0,       0, 32'h0,        0, 4'h0, 32'h0,        32'h0,        1, 1};
    vecs[12] = '{32'h8000_0000, 32'h0,        1, 0, 3'b011, 0, 0, 32'h0,        0, 32'h0,        0, 4'h0, 32'h0,        32'h0,        1, 1};
    vecs[13] = '{32'h8000_0001, 32'h0000_1111, 0, 1, 3'b001, 0, 0, 32'h0,       0, 32'h0,        0, 4'h0, 32'h0,        32'h0,        1, 1};
    vecs[14] = '{32'h8000_0000, 32'h0000_2222, 0, 1, 3'b100, 0, 0, 32'h0,       0, 32'h0,        0, 4'h0, 32'h0,        32'h0,        1, 1};
    vecs[15] = '{32'h8000_0000, 32'h0,        1, 0, 3'b000, 0, 1, 32'h1234_5678, 1, 32'h8000_0000, 0, 4'h0, 32'h0,        32'h0,        1, 3};
    vecs[16] = '{32'h0000_0055, 32'h0,        0, 0, 3'b000, 1, 0, 32'h0,        0, 32'h0,        0, 4'h0, 32'h0,        32'h0000_0055, 0, 1};

    rst = 1'b1;
    prev_valid = 1'b0; pc_i = '0; inst_i = '0; ebreak_i = 1'b0; rd_i = '0;
    result_i = '0; sdata_i = '0; mem_ren_i = 1'b0; mem_wen_i = 1'b0; funct3_i = '0;
    next_ready = 1'b0;
    bus.req_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_rdata = '0; bus.rsp_err = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, ready_o}, 32'd1);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_req_valid", {31'd0, bus.req_valid}, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    check("rst_wdata", wdata_o, 32'd0);
    check("rst_pc", pc_o, 32'd0);
    rst = 1'b0;

    for (int unsigned i = 0; i < NVEC; i++) do_vec(i);

    // Store stalled 3 cycles by req_ready, answered with a bus error, then held by writeback.
    v = '{32'h8000_0010, 32'h1122_3344, 0, 1, 3'b010, 0, 1, 32'h0, 1,
          32'h8000_0010, 1, 4'hF, 32'h1122_3344, 32'h0, 1, 3};
    @(negedge clk);
    check("a_idle_ready", {31'd0, ready_o}, 32'd1);
    drive_op(32'h9000_0000, 32'h2000_0000, 5'd7, v);
    next_ready = 1'b0;
    e = '{pc: 32'h9000_0000, inst: 32'h2000_0000, ebreak: 1'b0, rd: 5'd7, wdata: 32'h0, err: 1'b1};
    sb.push_back(e);
    @(negedge clk);
    prev_valid = 1'b0;
    result_i = 32'hFFFF_FFFF; sdata_i = 32'h0; mem_wen_i = 1'b0; funct3_i = 3'b000;
    for (int unsigned k = 0; k < 4; k++) begin
      check("a_req_valid", {31'd0, bus.req_valid}, 32'd1);
      check("a_req_addr", bus.req_addr, v.e_addr);
      check("a_req_wdata", bus.req_wdata, v.e_bwdata);
      check("a_req_wstrb", {28'd0, bus.req_wstrb}, 32'hF);
      check("a_req_wen", {31'd0, bus.req_wen}, 32'd1);
      check("a_ready", {31'd0, ready_o}, 32'd0);
      if (k == 3) bus.req_ready = 1'b1;
      @(negedge clk);
    end
    bus.req_ready = 1'b0;
    check("a_wait_req", {31'd0, bus.req_valid}, 32'd0);
    bus.rsp_valid = 1'b1; bus.rsp_err = 1'b1; bus.rsp_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.rsp_valid = 1'b0; bus.rsp_err = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (k == 0) compare_out();
      check("a_hold_valid", {31'd0, valid_o}, 32'd1);
      check("a_hold_ready", {31'd0, ready_o}, 32'd0);
      check("a_hold_err", {31'd0, err_o}, 32'd1);
      check("a_hold_wdata", wdata_o, 32'd0);
      check("a_hold_pc", pc_o, 32'h9000_0000);
      @(negedge clk);
    end
    next_ready = 1'b1;
    check("a_still_valid", {31'd0, valid_o}, 32'd1);
    @(negedge clk);
    check("a_release_valid", {31'd0, valid_o}, 32'd0);
    check("a_release_ready", {31'd0, ready_o}, 32'd1);

    // Reset while waiting for a load response; the late response must be ignored.
    v = '{32'h8000_0020, 32'h0, 1, 0, 3'b010, 0, 1, 32'h0, 0,
          32'h8000_0020, 0, 4'h0, 32'h0, 32'h0, 0, 3};
    @(negedge clk);
    drive_op(32'h9000_0100, 32'h3000_0000, 5'd9, v);
    bus.req_ready = 1'b1;
    @(negedge clk);
    prev_valid = 1'b0;
    check("b_req_valid", {31'd0, bus.req_valid}, 32'd1);
    @(negedge clk);
    bus.req_ready = 1'b0;
    check("b_wait_req", {31'd0, bus.req_valid}, 32'd0);
    check("b_wait_ready", {31'd0, ready_o}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("b_rst_ready", {31'd0, ready_o}, 32'd1);
    check("b_rst_valid", {31'd0, valid_o}, 32'd0);
    check("b_rst_req", {31'd0, bus.req_valid}, 32'd0);
    check("b_rst_wdata", wdata_o, 32'd0);
    bus.rsp_valid = 1'b1; bus.rsp_rdata = 32'hBADB_AD00;
    @(negedge clk);
    bus.rsp_valid = 1'b0;
    check("b_stale_valid", {31'd0, valid_o}, 32'd0);
    check("b_stale_ready", {31'd0, ready_o}, 32'd1);
    check("b_stale_wdata", wdata_o, 32'd0);
    do_vec(1);
    do_vec(0);

    check("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
